// File: rtl/addr_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_latch_pkg
// Description : Shared types and helpers for the addressable-latch scan block:
//               write-mode encodings, sequencer state, counter-width function.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_latch_pkg;

    // Number of addressable latch slots (one per mux select value)
    localparam int c_num_slots = 8;

    // Write mode, encoded directly from {CLR_n, E_n}
    typedef enum logic [1:0] {
        MODE_DEMUX  = 2'b00,  // addressed bit <= D, all others cleared
        MODE_CLEAR  = 2'b01,  // every bit cleared
        MODE_LATCH  = 2'b10,  // addressed bit <= D, all others hold
        MODE_MEMORY = 2'b11   // every bit holds
    } mode_t;

    // Address sequencer state
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,   // external address drives the latch
        ST_SCANNING = 1'b1    // internal slot address drives the latch
    } state_t;

    // Ceiling log2 with a floor of 1, so a single-cycle dwell still gets a
    // one-bit counter rather than a zero-width vector.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage : addr_latch_pkg
`default_nettype wire

// File: rtl/scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : scan_seq
// Description : Slot address sequencer. Holds each select address for DWELL
//               cycles, strobes a write on the last cycle of every slot and
//               pulses o_frame_done once the final slot has been sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_seq
    import addr_latch_pkg::*;
#(
    parameter int DWELL = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scan,
    output logic       o_wr_stb,
    output logic       o_active,
    output logic [2:0] o_slot,
    output logic       o_frame_done
);

    localparam int              CNT_W      = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sa;
    logic             r_frame_done;

    logic             w_last_cycle;

    // The last dwell cycle of a slot is the only cycle that samples D.
    assign w_last_cycle = (r_cnt == c_cnt_last);

    // Write strobe only while scanning continues; a falling SCAN never writes.
    assign o_wr_stb     = (r_state == ST_SCANNING) && i_scan && w_last_cycle;
    assign o_active     = (r_state == ST_SCANNING);
    assign o_slot       = r_sa;
    assign o_frame_done = r_frame_done;

    // Sequencer FSM: dwell counter, slot address and frame pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sa         <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Entry always lands on slot 0 with a fresh dwell count.
                    r_cnt <= '0;
                    r_sa  <= 3'd0;
                    if (i_scan) begin
                        r_state <= ST_SCANNING;
                    end
                end
                ST_SCANNING: begin
                    if (!i_scan) begin
                        // Abort: drop back to idle with no frame pulse.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_sa    <= 3'd0;
                    end else if (w_last_cycle) begin
                        r_cnt <= '0;
                        r_sa  <= r_sa + 3'd1;
                        if (r_sa == 3'(c_num_slots - 1)) begin
                            r_frame_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_sa    <= 3'd0;
                end
            endcase
        end
    end

endmodule : scan_seq
`default_nettype wire

// File: rtl/addr_latch_8_scan.sv
`default_nettype none
// ============================================================================
// Module      : addr_latch_8_scan
// Description : Clocked 74LS259-style 8-bit addressable latch / 1-of-8 demux
//               with an optional auto-scan sequencer that drives an upstream
//               8:1 mux select and rebuilds the parallel byte from its output.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_latch_8_scan
    import addr_latch_pkg::*;
#(
    parameter int DWELL = 4
)
(
    input  logic CLK,
    input  logic RST_n,
    input  logic E_n,
    input  logic CLR_n,
    input  logic SCAN,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    input  logic D,
    output logic Q7,
    output logic Q6,
    output logic Q5,
    output logic Q4,
    output logic Q3,
    output logic Q2,
    output logic Q1,
    output logic Q0,
    output logic SA2,
    output logic SA1,
    output logic SA0,
    output logic FRAME_DONE
);

    logic [7:0] r_q;

    logic       w_scan_wr;
    logic       w_scan_active;
    logic [2:0] w_slot;
    logic       w_frame_done;

    mode_t      w_mode;
    logic       w_ext_wr;
    logic       w_write;
    logic       w_hold_exit;
    logic [2:0] w_addr;
    logic [7:0] w_onehot;

    scan_seq #(
        .DWELL        (DWELL)
    ) u_scan_seq (
        .clk          (CLK),
        .rst_n        (RST_n),
        .i_scan       (SCAN),
        .o_wr_stb     (w_scan_wr),
        .o_active     (w_scan_active),
        .o_slot       (w_slot),
        .o_frame_done (w_frame_done)
    );

    assign w_mode      = mode_t'({CLR_n, E_n});

    // Idle with SCAN low: every edge writes at the external address.
    assign w_ext_wr    = !w_scan_active && !SCAN;
    assign w_write     = w_ext_wr || w_scan_wr;

    // The edge that leaves scanning keeps Q untouched whatever the mode.
    assign w_hold_exit = w_scan_active && !SCAN;

    assign w_addr      = w_ext_wr ? {A2, A1, A0} : w_slot;
    assign w_onehot    = 8'b0000_0001 << w_addr;

    // Latch array: mode applied on write edges; clear also acts between writes.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_q <= 8'h00;
        end else if (w_write) begin
            case (w_mode)
                MODE_LATCH:  r_q[w_addr] <= D;
                MODE_MEMORY: r_q         <= r_q;
                MODE_DEMUX:  r_q         <= D ? w_onehot : 8'h00;
                MODE_CLEAR:  r_q         <= 8'h00;
                default:     r_q         <= r_q;
            endcase
        end else if (!w_hold_exit && (w_mode == MODE_CLEAR)) begin
            r_q <= 8'h00;
        end
    end

    assign {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0} = r_q;
    assign {SA2, SA1, SA0}                  = w_slot;
    assign FRAME_DONE                       = w_frame_done;

endmodule : addr_latch_8_scan
`default_nettype wire

// File: tb/tb_addr_latch_8_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_latch_8_scan
// Description : Scoreboard bench for addr_latch_8_scan. One instance runs with
//               DWELL=4, a second with DWELL=1. Stimulus queues the expected
//               Q/SA for each edge and the expected FRAME_DONE cycles; a
//               monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_latch_8_scan;

    typedef struct packed {
        int         cyc;
        int         dut;
        logic [7:0] q;
        logic [2:0] sa;
    } chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;

    chk_t  exp_q[$];
    string nm_q[$];
    int    fd4_q[$];
    int    fd1_q[$];

    logic [7:0] cur;

    // DWELL = 4 instance
    logic       rst4_n, e4_n, clr4_n, scan4, d4_dir, fd4;
    logic [2:0] a4, sa4;
    logic [7:0] src4, q4;
    logic       d4;
    // Upstream 74LS151 model: Y follows the byte bit picked by SA.
    assign d4 = scan4 ? src4[sa4] : d4_dir;

    addr_latch_8_scan #(.DWELL(4)) u_dut4 (
        .CLK(clk), .RST_n(rst4_n), .E_n(e4_n), .CLR_n(clr4_n), .SCAN(scan4),
        .A2(a4[2]), .A1(a4[1]), .A0(a4[0]), .D(d4),
        .Q7(q4[7]), .Q6(q4[6]), .Q5(q4[5]), .Q4(q4[4]),
        .Q3(q4[3]), .Q2(q4[2]), .Q1(q4[1]), .Q0(q4[0]),
        .SA2(sa4[2]), .SA1(sa4[1]), .SA0(sa4[0]), .FRAME_DONE(fd4)
    );

    // DWELL = 1 instance
    logic       rst1_n, e1_n, clr1_n, scan1, fd1;
    logic [2:0] sa1;
    logic [7:0] src1, q1;
    logic       d1;
    assign d1 = scan1 ? src1[sa1] : 1'b0;

    addr_latch_8_scan #(.DWELL(1)) u_dut1 (
        .CLK(clk), .RST_n(rst1_n), .E_n(e1_n), .CLR_n(clr1_n), .SCAN(scan1),
        .A2(1'b0), .A1(1'b0), .A0(1'b0), .D(d1),
        .Q7(q1[7]), .Q6(q1[6]), .Q5(q1[5]), .Q4(q1[4]),
        .Q3(q1[3]), .Q2(q1[2]), .Q1(q1[1]), .Q0(q1[0]),
        .SA2(sa1[2]), .SA1(sa1[1]), .SA0(sa1[0]), .FRAME_DONE(fd1)
    );

    // Monitor state
    chk_t       e;
    string      en;
    logic [7:0] act_q;
    logic [2:0] act_sa;
    logic       fd_exp;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            en = nm_q.pop_front();
            act_q  = (e.dut == 4) ? q4  : q1;
            act_sa = (e.dut == 4) ? sa4 : sa1;
            checks++;
            if (e.cyc != cyc || act_q !== e.q || act_sa !== e.sa) begin
                failures++;
                $display("FAIL %s: dut%0d cyc %0d got Q=%02h SA=%0d, required Q=%02h SA=%0d",
                         en, e.dut, cyc, act_q, act_sa, e.q, e.sa);
            end
        end
        fd_exp = (fd4_q.size() > 0 && fd4_q[0] == cyc);
        if (fd_exp) void'(fd4_q.pop_front());
        if (fd_exp || fd4 !== 1'b0) begin
            checks++;
            if (fd4 !== fd_exp) begin
                failures++;
                $display("FAIL frame_done4: cyc %0d got %b required %b", cyc, fd4, fd_exp);
            end
        end
        fd_exp = (fd1_q.size() > 0 && fd1_q[0] == cyc);
        if (fd_exp) void'(fd1_q.pop_front());
        if (fd_exp || fd1 !== 1'b0) begin
            checks++;
            if (fd1 !== fd_exp) begin
                failures++;
                $display("FAIL frame_done1: cyc %0d got %b required %b", cyc, fd1, fd_exp);
            end
        end
    end

    // Queue the state expected after the coming edge, then take that edge.
    task automatic step(input int dut, input logic [7:0] q, input logic [2:0] sa, input string nm);
        chk_t c;
        c.cyc = cyc + 1;
        c.dut = dut;
        c.q   = q;
        c.sa  = sa;
        exp_q.push_back(c);
        nm_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    // Run n scan slots from slot 0; final_q is the hand-computed byte after slot n-1.
    task automatic run_slots(input int dut, input int dwell, input int n,
                             input logic [7:0] src, input logic [7:0] final_q);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < dwell - 1; j++) begin
                step(dut, cur, 3'(k), "scan_dwell");
            end
            cur[k] = src[k];
            if (k == n - 1) cur = final_q;
            if (k == 7) begin
                if (dut == 4) fd4_q.push_back(cyc + 1);
                else          fd1_q.push_back(cyc + 1);
            end
            step(dut, cur, 3'(k + 1), "scan_write");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst4_n = 1'b0; e4_n = 1'b1; clr4_n = 1'b1; scan4 = 1'b0;
        a4 = 3'd0; d4_dir = 1'b0; src4 = 8'h00;
        rst1_n = 1'b0; e1_n = 1'b1; clr1_n = 1'b1; scan1 = 1'b0; src1 = 8'h00;
        cur = 8'h00;
        #2;

        step(4, 8'h00, 3'd0, "reset_init");
        step(4, 8'h00, 3'd0, "reset_init");

        // Preload Q to 0xFF through the latch path
        rst4_n = 1'b1; e4_n = 1'b0; d4_dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a4 = 3'(i);
            step(4, 8'((9'h001 << (i + 1)) - 9'h001), 3'd0, "preload");
        end

        // Reset wins over an active latch write
        rst4_n = 1'b0; a4 = 3'd3;
        step(4, 8'h00, 3'd0, "reset_clears");
        rst4_n = 1'b1;

        // Latch mode
        a4 = 3'd5; d4_dir = 1'b1; step(4, 8'h20, 3'd0, "latch_a5");
        a4 = 3'd2; d4_dir = 1'b1; step(4, 8'h24, 3'd0, "latch_a2");

        // Memory mode, D and A wiggling
        e4_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4_dir = i[0];
            a4     = 3'(i);
            step(4, 8'h24, 3'd0, "memory_hold");
        end

        // Demux and clear
        clr4_n = 1'b0; e4_n = 1'b0; a4 = 3'd7; d4_dir = 1'b1;
        step(4, 8'h80, 3'd0, "demux_a7");
        e4_n = 1'b1;
        step(4, 8'h00, 3'd0, "clear");
        clr4_n = 1'b1; e4_n = 1'b0; a4 = 3'd1; d4_dir = 1'b1;
        step(4, 8'h02, 3'd0, "latch_a1");
        clr4_n = 1'b0; a4 = 3'd6; d4_dir = 1'b0;
        step(4, 8'h00, 3'd0, "demux_d0");

        // Full scan frame, byte 0xA5
        clr4_n = 1'b1; e4_n = 1'b0; src4 = 8'hA5; scan4 = 1'b1;
        cur = 8'h00;
        step(4, 8'h00, 3'd0, "scan_entry");
        run_slots(4, 4, 8, 8'hA5, 8'hA5);

        // Back-to-back frame with byte 0x5A, aborted in slot 3
        src4 = 8'h5A;
        run_slots(4, 4, 3, 8'h5A, 8'hA2);
        step(4, 8'hA2, 3'd3, "slot3_dwell");
        step(4, 8'hA2, 3'd3, "slot3_dwell");
        scan4 = 1'b0; a4 = 3'd1; d4_dir = 1'b0;
        step(4, 8'hA2, 3'd0, "abort_hold");
        e4_n = 1'b1;
        step(4, 8'hA2, 3'd0, "idle_hold");

        // Restart from slot 0 and complete the frame
        e4_n = 1'b0; scan4 = 1'b1;
        cur = 8'hA2;
        step(4, 8'hA2, 3'd0, "rescan_entry");
        run_slots(4, 4, 8, 8'h5A, 8'h5A);
        scan4 = 1'b0; e4_n = 1'b1;
        step(4, 8'h5A, 3'd0, "exit_after_frame");

        // DWELL = 1: partial frame, reset at the slot-7 edge, then a full frame
        step(1, 8'h00, 3'd0, "d1_reset");
        rst1_n = 1'b1; e1_n = 1'b0; clr1_n = 1'b1; scan1 = 1'b1; src1 = 8'h3C;
        cur = 8'h00;
        step(1, 8'h00, 3'd0, "d1_entry");
        run_slots(1, 1, 7, 8'h3C, 8'h3C);
        rst1_n = 1'b0;
        step(1, 8'h00, 3'd0, "d1_mid_reset");
        rst1_n = 1'b1;
        cur = 8'h00;
        step(1, 8'h00, 3'd0, "d1_rescan_entry");
        run_slots(1, 1, 8, 8'h3C, 8'h3C);
        scan1 = 1'b0;
        step(1, 8'h3C, 3'd0, "d1_exit");

        @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_checks: got %0d pending required 0", exp_q.size());
        end
        if (fd4_q.size() != 0 || fd1_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_frame_done: got %0d pending required 0",
                     fd4_q.size() + fd1_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_addr_latch_8_scan
`default_nettype wire
